// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control unit.
// Sequences IF/ID/EX/MEM/WB over a 32-bit IR, with a memory wait counter
// that traps after MEM_TIMEOUT stalled cycles and a TRAP state for illegal
// instructions.
//
// state | meaning
// IF    | fetch: request memory, load IR and PC+4 on mem_ready
// ID    | decode IR; j/jal/jr update PC here, illegal ops go to TRAP
// EX    | ALU execute; branches resolve here using cond
// MEM   | data access for lw/sw, waits for mem_ready
// WB    | register write-back
// TRAP  | illegal instruction or memory timeout; held until reset
module mc_ctrl #(
    parameter int ALUOP_W     = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int EN_JAL      = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        instr,
    input  logic               mem_ready,
    input  logic               cond,
    output logic               mem_req,
    output logic               mem_we,
    output logic               ir_we,
    output logic               pc_we,
    output logic [1:0]         pc_src,
    output logic               reg_we,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem2reg,
    output logic               alu_srcB,
    output logic [1:0]         ext_op,
    output logic [ALUOP_W-1:0] alu_ctrl,
    output logic               illegal,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd5
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_ADDU = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_SUBU = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_EQL  = 4'd9;
    localparam logic [3:0] ALU_BNE  = 4'd10;

    localparam bit         JAL_ON   = (EN_JAL != 0);
    localparam logic [7:0] WAIT_MAX = 8'(MEM_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;

    logic [5:0]  op, funct;
    logic        dec_legal, is_rtype, is_j, is_jal, is_jr;
    logic        is_branch, is_lw, is_sw;
    logic [3:0]  dec_alu;
    logic        dec_srcb;
    logic [1:0]  dec_ext;
    logic        timeout;
    logic        unused_ir;

    assign op        = ir_q[31:26];
    assign funct     = ir_q[5:0];
    assign unused_ir = ^ir_q[25:6];
    assign timeout   = (wait_cnt_q == WAIT_MAX);
    assign state     = state_q;

    // Instruction decode from IR: legality, class flags and ALU controls.
    always_comb begin
        dec_legal = 1'b0;
        is_rtype  = 1'b0;
        is_j      = 1'b0;
        is_jal    = 1'b0;
        is_jr     = 1'b0;
        is_branch = 1'b0;
        is_lw     = 1'b0;
        is_sw     = 1'b0;
        dec_alu   = ALU_ADD;
        dec_srcb  = 1'b0;
        dec_ext   = 2'd0;
        case (op)
            OP_R: begin
                is_rtype  = 1'b1;
                dec_legal = 1'b1;
                case (funct)
                    6'h20:   dec_alu = ALU_ADD;
                    6'h21:   dec_alu = ALU_ADDU;
                    6'h22:   dec_alu = ALU_SUB;
                    6'h23:   dec_alu = ALU_SUBU;
                    6'h24:   dec_alu = ALU_AND;
                    6'h25:   dec_alu = ALU_OR;
                    6'h2A:   dec_alu = ALU_SLT;
                    6'h00:   dec_alu = ALU_SLL;
                    6'h02:   dec_alu = ALU_SRL;
                    6'h08: begin
                        is_jr     = JAL_ON;
                        dec_legal = JAL_ON;
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            OP_J:    begin dec_legal = 1'b1; is_j = 1'b1; end
            OP_JAL:  begin dec_legal = JAL_ON; is_jal = JAL_ON; end
            OP_BEQ:  begin dec_legal = 1'b1; is_branch = 1'b1; dec_alu = ALU_EQL; dec_ext = 2'd1; end
            OP_BNE:  begin dec_legal = 1'b1; is_branch = 1'b1; dec_alu = ALU_BNE; dec_ext = 2'd1; end
            OP_SLTI: begin dec_legal = 1'b1; dec_alu = ALU_SLT; dec_srcb = 1'b1; dec_ext = 2'd1; end
            OP_ORI:  begin dec_legal = 1'b1; dec_alu = ALU_OR; dec_srcb = 1'b1; end
            OP_LUI:  begin dec_legal = 1'b1; dec_alu = ALU_ADDU; dec_srcb = 1'b1; dec_ext = 2'd2; end
            OP_LW:   begin dec_legal = 1'b1; is_lw = 1'b1; dec_srcb = 1'b1; dec_ext = 2'd1; end
            OP_SW:   begin dec_legal = 1'b1; is_sw = 1'b1; dec_srcb = 1'b1; dec_ext = 2'd1; end
            default: dec_legal = 1'b0;
        endcase
        if (!dec_legal) begin
            dec_alu  = ALU_ADD;
            dec_srcb = 1'b0;
            dec_ext  = 2'd0;
        end
    end

    // Next-state, datapath strobes and wait counter; outputs forced low in reset.
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        wait_cnt_d = 8'd0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 2'd0;
        reg_we     = 1'b0;
        reg_dst    = 2'd0;
        mem2reg    = 2'd0;
        alu_srcB   = 1'b0;
        ext_op     = 2'd0;
        alu_ctrl   = '0;
        illegal    = 1'b0;
        case (state_q)
            S_IF: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    ir_d    = instr;
                    state_d = S_ID;
                end else if (timeout) begin
                    state_d = S_TRAP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_ID: begin
                if (!dec_legal) begin
                    state_d = S_TRAP;
                end else if (is_j) begin
                    pc_we   = 1'b1;
                    pc_src  = 2'd2;
                    state_d = S_IF;
                end else if (is_jal) begin
                    pc_we   = 1'b1;
                    pc_src  = 2'd2;
                    state_d = S_WB;
                end else if (is_jr) begin
                    pc_we   = 1'b1;
                    pc_src  = 2'd3;
                    state_d = S_IF;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                if (is_branch) begin
                    pc_we   = cond;
                    pc_src  = 2'd1;
                    state_d = S_IF;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = is_sw;
                if (mem_ready) begin
                    state_d = is_sw ? S_IF : S_WB;
                end else if (timeout) begin
                    state_d = S_TRAP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                reg_dst = is_rtype ? 2'd1 : (is_jal ? 2'd2 : 2'd0);
                mem2reg = is_lw ? 2'd1 : (is_jal ? 2'd2 : 2'd0);
                state_d = S_IF;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase
        if (state_q inside {S_ID, S_EX, S_MEM, S_WB}) begin
            alu_ctrl = ALUOP_W'(dec_alu);
            alu_srcB = dec_srcb;
            ext_op   = dec_ext;
        end
        if (rst) begin
            mem_req  = 1'b0;
            mem_we   = 1'b0;
            ir_we    = 1'b0;
            pc_we    = 1'b0;
            pc_src   = 2'd0;
            reg_we   = 1'b0;
            reg_dst  = 2'd0;
            mem2reg  = 2'd0;
            alu_srcB = 1'b0;
            ext_op   = 2'd0;
            alu_ctrl = '0;
            illegal  = 1'b0;
        end
    end

    // State, IR and wait counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IF;
            ir_q       <= 32'd0;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed scenarios plus randomized
// instruction streams, checked against a per-instruction phase model.
module tb_mc_ctrl;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] mem2reg;
        logic       alu_srcb;
        logic [1:0] ext_op;
        logic [4:0] alu_ctrl;
        logic       illegal;
        logic [2:0] state;
    } out_t;

    typedef enum {C_R, C_ORI, C_SLTI, C_LUI, C_LW, C_SW, C_BEQ, C_BNE,
                  C_J, C_JAL, C_JR, C_ILL} cls_t;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        mem_ready;
    logic        cond;

    logic       mem_req_a, mem_we_a, ir_we_a, pc_we_a, reg_we_a, srcb_a, illegal_a;
    logic [1:0] pc_src_a, reg_dst_a, mem2reg_a, ext_op_a;
    logic [4:0] alu_ctrl_a;
    logic [2:0] state_a;
    logic       mem_req_b, mem_we_b, ir_we_b, pc_we_b, reg_we_b, srcb_b, illegal_b;
    logic [1:0] pc_src_b, reg_dst_b, mem2reg_b, ext_op_b;
    logic [4:0] alu_ctrl_b;
    logic [2:0] state_b;

    out_t obs_a, obs_b;
    int   checks = 0;
    int   errors = 0;

    mc_ctrl #(.ALUOP_W(5), .MEM_TIMEOUT(16), .EN_JAL(1)) dut_a (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .cond(cond),
        .mem_req(mem_req_a), .mem_we(mem_we_a), .ir_we(ir_we_a), .pc_we(pc_we_a),
        .pc_src(pc_src_a), .reg_we(reg_we_a), .reg_dst(reg_dst_a), .mem2reg(mem2reg_a),
        .alu_srcB(srcb_a), .ext_op(ext_op_a), .alu_ctrl(alu_ctrl_a),
        .illegal(illegal_a), .state(state_a)
    );

    mc_ctrl #(.ALUOP_W(5), .MEM_TIMEOUT(16), .EN_JAL(0)) dut_b (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .cond(cond),
        .mem_req(mem_req_b), .mem_we(mem_we_b), .ir_we(ir_we_b), .pc_we(pc_we_b),
        .pc_src(pc_src_b), .reg_we(reg_we_b), .reg_dst(reg_dst_b), .mem2reg(mem2reg_b),
        .alu_srcB(srcb_b), .ext_op(ext_op_b), .alu_ctrl(alu_ctrl_b),
        .illegal(illegal_b), .state(state_b)
    );

    assign obs_a = {mem_req_a, mem_we_a, ir_we_a, pc_we_a, pc_src_a, reg_we_a, reg_dst_a,
                    mem2reg_a, srcb_a, ext_op_a, alu_ctrl_a, illegal_a, state_a};
    assign obs_b = {mem_req_b, mem_we_b, ir_we_b, pc_we_b, pc_src_b, reg_we_b, reg_dst_b,
                    mem2reg_b, srcb_b, ext_op_b, alu_ctrl_b, illegal_b, state_b};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic cls_t classify(input logic [31:0] w, input bit en_jal);
        logic [5:0] op;
        logic [5:0] fn;
        op = w[31:26];
        fn = w[5:0];
        case (op)
            6'h00: begin
                if (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02})
                    return C_R;
                if (fn == 6'h08) return en_jal ? C_JR : C_ILL;
                return C_ILL;
            end
            6'h02: return C_J;
            6'h03: return en_jal ? C_JAL : C_ILL;
            6'h04: return C_BEQ;
            6'h05: return C_BNE;
            6'h0A: return C_SLTI;
            6'h0D: return C_ORI;
            6'h0F: return C_LUI;
            6'h23: return C_LW;
            6'h2B: return C_SW;
            default: return C_ILL;
        endcase
    endfunction

    // ALU-side controls an instruction should present while it is in flight.
    function automatic out_t alu_fields(input logic [31:0] w, input cls_t c);
        out_t e;
        e = '0;
        case (c)
            C_R: case (w[5:0])
                6'h20: e.alu_ctrl = 5'd0;
                6'h21: e.alu_ctrl = 5'd1;
                6'h22: e.alu_ctrl = 5'd2;
                6'h23: e.alu_ctrl = 5'd3;
                6'h24: e.alu_ctrl = 5'd4;
                6'h25: e.alu_ctrl = 5'd5;
                6'h00: e.alu_ctrl = 5'd6;
                6'h02: e.alu_ctrl = 5'd7;
                6'h2A: e.alu_ctrl = 5'd8;
                default: e.alu_ctrl = 5'd0;
            endcase
            C_ORI:  begin e.alu_ctrl = 5'd5;  e.alu_srcb = 1'b1; e.ext_op = 2'd0; end
            C_SLTI: begin e.alu_ctrl = 5'd8;  e.alu_srcb = 1'b1; e.ext_op = 2'd1; end
            C_LUI:  begin e.alu_ctrl = 5'd1;  e.alu_srcb = 1'b1; e.ext_op = 2'd2; end
            C_LW, C_SW: begin e.alu_ctrl = 5'd0; e.alu_srcb = 1'b1; e.ext_op = 2'd1; end
            C_BEQ:  begin e.alu_ctrl = 5'd9;  e.ext_op = 2'd1; end
            C_BNE:  begin e.alu_ctrl = 5'd10; e.ext_op = 2'd1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic out_t trap_out();
        out_t e;
        e = '0;
        e.illegal = 1'b1;
        e.state = 3'd5;
        return e;
    endfunction

    function automatic out_t fetch_out(input bit rdy);
        out_t e;
        e = '0;
        e.mem_req = 1'b1;
        e.ir_we = rdy;
        e.pc_we = rdy;
        return e;
    endfunction

    task automatic chk(input out_t obs, input out_t exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input out_t exp, input string tag);
        @(negedge clk);
        chk(obs_a, exp, tag);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        out_t z;
        z = '0;
        rst = 1'b1;
        mem_ready = 1'b1;
        cond = 1'b1;
        #1;
        chk(obs_a, z, "RST_a");
        chk(obs_b, z, "RST_b");
        @(negedge clk);
        chk(obs_a, z, "RST_hold");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Drives one instruction through the DUT from IF and checks every cycle.
    task automatic run_instr(input logic [31:0] w, input int if_stall,
                             input int mem_stall, input bit cv);
        cls_t c;
        out_t base, e;
        c = classify(w, 1'b1);
        base = alu_fields(w, c);
        instr = w;
        cond = cv;
        for (int k = 0; k <= if_stall; k++) begin
            mem_ready = (k == if_stall);
            step(fetch_out(k == if_stall), "IF");
        end
        instr = $urandom;
        mem_ready = 1'($urandom);
        e = base;
        e.state = 3'd1;
        if (c inside {C_J, C_JAL}) begin e.pc_we = 1'b1; e.pc_src = 2'd2; end
        if (c == C_JR) begin e.pc_we = 1'b1; e.pc_src = 2'd3; end
        step(e, "ID");
        if (c == C_ILL) begin
            step(trap_out(), "TRAP");
            mem_ready = 1'b1;
            step(trap_out(), "TRAP_hold");
            do_reset();
            return;
        end
        if (c inside {C_J, C_JR}) return;
        if (c != C_JAL) begin
            mem_ready = 1'($urandom);
            e = base;
            e.state = 3'd2;
            if (c inside {C_BEQ, C_BNE}) begin e.pc_we = cv; e.pc_src = 2'd1; end
            step(e, "EX");
            if (c inside {C_BEQ, C_BNE}) return;
            if (c inside {C_LW, C_SW}) begin
                for (int k = 0; k <= mem_stall; k++) begin
                    mem_ready = (k == mem_stall);
                    e = base;
                    e.state = 3'd3;
                    e.mem_req = 1'b1;
                    e.mem_we = (c == C_SW);
                    step(e, "MEM");
                end
                if (c == C_SW) return;
            end
        end
        mem_ready = 1'($urandom);
        e = base;
        e.state = 3'd4;
        e.reg_we = 1'b1;
        e.reg_dst = (c == C_R) ? 2'd1 : ((c == C_JAL) ? 2'd2 : 2'd0);
        e.mem2reg = (c == C_LW) ? 2'd1 : ((c == C_JAL) ? 2'd2 : 2'd0);
        step(e, "WB");
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [5:0]  op;
        logic [5:0]  fn;
        int          kind;
        logic [5:0]  ops[9];
        logic [5:0]  fns[9];
        ops = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h0A, 6'h0D, 6'h0F, 6'h23, 6'h2B};
        fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02};
        w = $urandom;
        kind = $urandom_range(0, 13);
        if (kind <= 2) begin
            w[31:26] = 6'h00;
            w[5:0] = fns[$urandom_range(0, 8)];
        end else if (kind <= 10) begin
            w[31:26] = ops[$urandom_range(0, 8)];
        end else if (kind == 11) begin
            w[31:26] = 6'h00;
            w[5:0] = 6'h08;
        end else if (kind == 12) begin
            do op = 6'($urandom_range(0, 63));
            while (op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h0A, 6'h0D, 6'h0F, 6'h23, 6'h2B});
            w[31:26] = op;
        end else begin
            do fn = 6'($urandom_range(0, 63));
            while (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h08});
            w[31:26] = 6'h00;
            w[5:0] = fn;
        end
        return w;
    endfunction

    initial begin
        out_t e;
        rst = 1'b1;
        instr = 32'd0;
        mem_ready = 1'b0;
        cond = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // addu, zero wait
        run_instr(32'h00221821, 0, 0, 1'b0);
        // lw with MEM stalled 3 cycles
        run_instr(32'h8C220004, 0, 3, 1'b0);
        // beq not taken, then taken
        run_instr(32'h10220003, 0, 0, 1'b0);
        run_instr(32'h10220003, 0, 0, 1'b1);
        // sw, slti, lui, ori, j, jr
        run_instr(32'hAC220008, 1, 2, 1'b0);
        run_instr(32'h2822FFFF, 0, 0, 1'b1);
        run_instr(32'h3C021234, 2, 0, 1'b0);
        run_instr(32'h34420F0F, 0, 0, 1'b0);
        run_instr(32'h08000040, 0, 0, 1'b0);
        run_instr(32'h03E00008, 0, 0, 1'b0);

        // jal on both builds: enabled completes, disabled traps
        do_reset();
        run_instr(32'h0C000010, 0, 0, 1'b0);
        @(negedge clk);
        chk(obs_b, trap_out(), "JAL_DISABLED");
        @(posedge clk);
        #1;

        // fetch timeout: 16 stalled IF cycles trap
        do_reset();
        mem_ready = 1'b0;
        for (int k = 0; k < 16; k++) step(fetch_out(1'b0), "IF_WAIT");
        step(trap_out(), "IF_TIMEOUT");
        step(trap_out(), "IF_TIMEOUT_hold");

        // ready on the 16th IF cycle wins over the timeout
        do_reset();
        instr = 32'h00221821;
        mem_ready = 1'b0;
        for (int k = 0; k < 15; k++) step(fetch_out(1'b0), "IF_WAIT2");
        mem_ready = 1'b1;
        step(fetch_out(1'b1), "IF_LAST");
        e = alu_fields(32'h00221821, C_R);
        e.state = 3'd1;
        step(e, "ID_AFTER_LATE_READY");

        // MEM timeout on sw
        do_reset();
        instr = 32'hAC220008;
        mem_ready = 1'b1;
        step(fetch_out(1'b1), "SW_IF");
        e = alu_fields(32'hAC220008, C_SW);
        e.state = 3'd1;
        step(e, "SW_ID");
        e.state = 3'd2;
        step(e, "SW_EX");
        mem_ready = 1'b0;
        e.state = 3'd3;
        e.mem_req = 1'b1;
        e.mem_we = 1'b1;
        for (int k = 0; k < 16; k++) step(e, "SW_MEM_WAIT");
        step(trap_out(), "MEM_TIMEOUT");

        // reset pulsed mid-cycle during MEM of sw
        do_reset();
        mem_ready = 1'b1;
        step(fetch_out(1'b1), "SW2_IF");
        e = alu_fields(32'hAC220008, C_SW);
        e.state = 3'd1;
        step(e, "SW2_ID");
        e.state = 3'd2;
        step(e, "SW2_EX");
        mem_ready = 1'b0;
        @(negedge clk);
        e.state = 3'd3;
        e.mem_req = 1'b1;
        e.mem_we = 1'b1;
        chk(obs_a, e, "SW2_MEM");
        #2;
        rst = 1'b1;
        #1;
        chk(obs_a, out_t'('0), "RST_IN_MEM");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(fetch_out(1'b0), "FIRST_REQ_AFTER_RST");

        // randomized instruction stream
        do_reset();
        for (int n = 0; n < 80; n++) begin
            run_instr(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
